uart_frame_sender: RTL and testbench

- Serialises one framed packet per start request through the existing byte-level UART transmitter. The transmitter is driven over its send/ready handshake.
- Frame format: SYNC (0xA5), TYPE, LEN, LEN payload bytes, CHK.
- This is the FPGA-to-host direction, the counterpart of the host-command path that feeds the image transmit FSM. It returns status, delay tables and captured values to the PC.

---
 rtl/uart_frame_sender_pkg.sv | 24 ++
 rtl/uart_frame_sender_chk_accum.sv | 44 ++++
 rtl/uart_frame_sender.sv | 146 ++++++++++++++
 tb/tb_uart_frame_sender.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_sender_pkg.sv
// Shared types and constants for the framed UART sender (state codes, byte selectors, frame constants).
package uart_frame_sender_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_FINISH    = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    SEL_SYNC = 3'd0,
    SEL_TYPE = 3'd1,
    SEL_LEN  = 3'd2,
    SEL_PAY  = 3'd3,
    SEL_CHK  = 3'd4
  } sel_e;

  localparam logic [7:0] FRAME_SYNC = 8'hA5;
  localparam logic [7:0] CRC8_POLY  = 8'h07;

endpackage

// File: rtl/uart_frame_sender_chk_accum.sv
// Frame check accumulator: modulo-256 two's-complement sum by default, CRC-8 (poly 0x07,
// MSB-first, init 0) when FRAME_CRC8_EN is defined.
module frame_chk_accum
  import uart_frame_sender_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] byte_in,
  output logic [7:0] chk_out
);

  logic [7:0] acc_q;

`ifdef FRAME_CRC8_EN
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc_q <= 8'h00;
    else if (clr) acc_q <= 8'h00;
    else if (en)  acc_q <= crc8_next(acc_q, byte_in);
  end

  assign chk_out = acc_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc_q <= 8'h00;
    else if (clr) acc_q <= 8'h00;
    else if (en)  acc_q <= acc_q + byte_in;
  end

  // Negated sum makes TYPE..CHK add up to zero on the host side.
  assign chk_out = 8'h00 - acc_q;
`endif

endmodule

// File: rtl/uart_frame_sender.sv
// Sends SYNC/TYPE/LEN/payload/CHK frames through a byte UART over its send/ready handshake.
// Build option: FRAME_CRC8_EN selects CRC-8 instead of the two's-complement sum for CHK.
module uart_frame_sender
  import uart_frame_sender_pkg::*;
#(
  parameter int MAX_PAYLOAD = 16,
  parameter int LEN_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       frame_type,
  input  logic [LEN_W-1:0] payload_len,
  output logic [LEN_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             tx_send,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done,
  output logic             err_len
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);

  state_e           state_q, state_d;
  sel_e             sel_q;
  logic [LEN_W-1:0] pay_q;
  logic [LEN_W-1:0] len_q;
  logic [7:0]       type_q;
  logic             ld_ph_q;
  logic [7:0]       tx_data_q;
  logic             tx_send_q;
  logic             err_len_q;

  logic             too_long;
  logic             accept;
  logic             chk_en;
  logic             load_byte;
  logic [7:0]       byte_mux;
  logic [7:0]       chk_out;

  assign too_long = (payload_len > MAX_LEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start && !too_long) state_d = ST_LOAD;
      ST_LOAD:      if (sel_q != SEL_PAY || ld_ph_q) state_d = ST_ISSUE;
      ST_ISSUE:     if (tx_ready) state_d = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (!tx_ready) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (tx_ready) state_d = (sel_q == SEL_CHK) ? ST_FINISH : ST_LOAD;
      ST_FINISH:    state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_FINISH);
    accept    = (state_q == ST_IDLE) && start && !too_long;
    load_byte = (state_q == ST_LOAD) && (sel_q != SEL_PAY || ld_ph_q);
    chk_en    = (state_q == ST_WAIT_DONE) && tx_ready &&
                (sel_q == SEL_TYPE || sel_q == SEL_LEN || sel_q == SEL_PAY);
  end

  always_comb begin
    byte_mux = FRAME_SYNC;
    case (sel_q)
      SEL_SYNC: byte_mux = FRAME_SYNC;
      SEL_TYPE: byte_mux = type_q;
      SEL_LEN:  byte_mux = 8'(len_q);
      SEL_PAY:  byte_mux = rd_data;
      SEL_CHK:  byte_mux = chk_out;
      default:  byte_mux = FRAME_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= SEL_SYNC;
      pay_q     <= '0;
      len_q     <= '0;
      type_q    <= 8'h00;
      ld_ph_q   <= 1'b0;
      tx_data_q <= 8'h00;
      tx_send_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      err_len_q <= (state_q == ST_IDLE) && start && too_long;
      // Registered pulse: send goes out the cycle after ready is seen in ISSUE.
      tx_send_q <= (state_q == ST_ISSUE) && tx_ready;

      if (accept) begin
        type_q  <= frame_type;
        len_q   <= payload_len;
        sel_q   <= SEL_SYNC;
        pay_q   <= '0;
        ld_ph_q <= 1'b0;
      end

      // Payload bytes spend one extra LOAD cycle waiting for the buffer read.
      if (state_q == ST_LOAD) begin
        if (load_byte) begin
          tx_data_q <= byte_mux;
          ld_ph_q   <= 1'b0;
        end else begin
          ld_ph_q   <= 1'b1;
        end
      end

      if (state_q == ST_WAIT_DONE && tx_ready) begin
        case (sel_q)
          SEL_SYNC: sel_q <= SEL_TYPE;
          SEL_TYPE: sel_q <= SEL_LEN;
          SEL_LEN:  sel_q <= (len_q == '0) ? SEL_CHK : SEL_PAY;
          SEL_PAY: begin
            if (pay_q == len_q - LEN_W'(1)) sel_q <= SEL_CHK;
            else                            pay_q <= pay_q + LEN_W'(1);
          end
          default:  sel_q <= sel_q;
        endcase
      end
    end
  end

  frame_chk_accum u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .en      (chk_en),
    .byte_in (tx_data_q),
    .chk_out (chk_out)
  );

  assign rd_addr = pay_q;
  assign tx_data = tx_data_q;
  assign tx_send = tx_send_q;
  assign err_len = err_len_q;

endmodule

// File: tb/tb_uart_frame_sender.sv
// Directed bench for uart_frame_sender (default sum checksum) with a 10-cycle UART busy model.
module tb_uart_frame_sender;

  localparam int LEN_W       = 5;
  localparam int MAX_PAYLOAD = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [7:0]       frame_type = 8'h00;
  logic [LEN_W-1:0] payload_len = '0;
  logic [LEN_W-1:0] rd_addr;
  logic [7:0]       rd_data;
  logic             tx_send;
  logic [7:0]       tx_data;
  logic             tx_ready;
  logic             busy;
  logic             done;
  logic             err_len;

  uart_frame_sender #(.MAX_PAYLOAD(MAX_PAYLOAD), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .frame_type  (frame_type),
    .payload_len (payload_len),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .tx_send     (tx_send),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .err_len     (err_len)
  );

  always #5 clk = ~clk;

  // Payload buffer with one-cycle read latency.
  logic [7:0] mem [32];
  always @(posedge clk) rd_data <= mem[rd_addr];

  // UART model: byte accepted on tx_send, then busy for 10 cycles.
  logic       hold = 1'b0;
  int         ucnt;
  int         sends, bad_send, data_changed, done_cnt, err_cnt;
  logic [7:0] last_byte;
  logic [7:0] got_q [$];

  assign tx_ready = !hold && (ucnt == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ucnt <= 0;
    end else begin
      if (tx_send) begin
        got_q.push_back(tx_data);
        sends     <= sends + 1;
        ucnt      <= 10;
        last_byte <= tx_data;
        if (!tx_ready) bad_send <= bad_send + 1;
      end else if (ucnt > 0) begin
        ucnt <= ucnt - 1;
        if (tx_data !== last_byte) data_changed <= data_changed + 1;
      end
      if (done)    done_cnt <= done_cnt + 1;
      if (err_len) err_cnt  <= err_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] t, input logic [LEN_W-1:0] n);
    @(negedge clk);
    frame_type  = t;
    payload_len = n;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_done_after"}, 32'(done), 32'd0);
  endtask

  task automatic check_bytes(input string tag, input int base, input logic [7:0] exp [$]);
    check({tag, "_nbytes"}, 32'(got_q.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < got_q.size())
        check($sformatf("%s_b%0d", tag, i), 32'(got_q[base + i]), 32'(exp[i]));
    end
  endtask

  int base, s0, d0, e0;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_send", 32'(tx_send), 32'd0);
    check("rst_err", 32'(err_len), 32'd0);
    check("rst_addr", 32'(rd_addr), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // TYPE 0x10, three payload bytes
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    base = got_q.size(); s0 = sends; d0 = done_cnt;
    pulse_start(8'h10, 5'd3);
    wait_done("f1");
    check_bytes("f1", base, '{8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'hE7});
    check("f1_sends", 32'(sends - s0), 32'd7);
    check("f1_dones", 32'(done_cnt - d0), 32'd1);

    // Empty payload
    base = got_q.size();
    pulse_start(8'h20, 5'd0);
    wait_done("f0");
    check_bytes("f0", base, '{8'hA5, 8'h20, 8'h00, 8'hE0});

    // Oversized length is rejected
    s0 = sends; e0 = err_cnt;
    @(negedge clk);
    frame_type = 8'h55; payload_len = 5'd17; start = 1'b1;
    @(posedge clk);
    #1;
    check("len17_err", 32'(err_len), 32'd1);
    check("len17_busy", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("len17_sends", 32'(sends - s0), 32'd0);
    check("len17_busy_late", 32'(busy), 32'd0);
    check("len17_errcnt", 32'(err_cnt - e0), 32'd1);

    // Maximum length accepted: 16 bytes 0x00..0x0F, sum 0x10+0x10+0x78=0x98 -> CHK 0x68
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    base = got_q.size(); e0 = err_cnt;
    pulse_start(8'h10, 5'd16);
    wait_done("f16");
    check("f16_nbytes", 32'(got_q.size() - base), 32'd20);
    check("f16_b18", 32'(got_q[base + 18]), 32'h0F);
    check("f16_chk", 32'(got_q[base + 19]), 32'h68);
    check("f16_noerr", 32'(err_cnt - e0), 32'd0);

    // Start while busy is ignored
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    base = got_q.size(); s0 = sends; d0 = done_cnt;
    pulse_start(8'h10, 5'd3);
    repeat (30) @(negedge clk);
    pulse_start(8'h20, 5'd0);
    wait_done("mid");
    repeat (200) @(negedge clk);
    check_bytes("mid", base, '{8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'hE7});
    check("mid_sends", 32'(sends - s0), 32'd7);
    check("mid_dones", 32'(done_cnt - d0), 32'd1);
    check("mid_busy", 32'(busy), 32'd0);

    // Transmitter not ready for 50 cycles before the first byte
    mem[0] = 8'h44;
    base = got_q.size(); s0 = sends;
    @(negedge clk);
    hold = 1'b1;
    pulse_start(8'h33, 5'd1);
    repeat (50) @(negedge clk);
    check("hold_send", 32'(tx_send), 32'd0);
    check("hold_sends", 32'(sends - s0), 32'd0);
    hold = 1'b0;
    @(posedge clk);
    #1;
    check("hold_first_pulse", 32'(tx_send), 32'd1);
    wait_done("hold");
    check_bytes("hold", base, '{8'hA5, 8'h33, 8'h01, 8'h44, 8'h88});

    // Reset during the second payload byte, then a fresh frame
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    s0 = sends;
    pulse_start(8'h10, 5'd3);
    for (int i = 0; i < 2000 && (sends - s0) < 5; i++) @(negedge clk);
    check("rst_mid_reached", 32'(sends - s0), 32'd5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_send", 32'(tx_send), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s0 = sends;
    repeat (30) @(negedge clk);
    check("rst_mid_idle_sends", 32'(sends - s0), 32'd0);
    base = got_q.size();
    pulse_start(8'h20, 5'd0);
    wait_done("post_rst");
    check_bytes("post_rst", base, '{8'hA5, 8'h20, 8'h00, 8'hE0});

    check("send_while_not_ready", 32'(bad_send), 32'd0);
    check("tx_data_changed_while_busy", 32'(data_changed), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
